// File: rtl/flit_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one transmit link.
// Grants lock HEAD..TAIL, output is a registered valid/ready slot.
module flit_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int FLIT_WIDTH     = 128,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [3:0]                      noc_state,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*FLIT_WIDTH-1:0]   req_flit,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            out_valid,
    output logic [FLIT_WIDTH-1:0]           out_flit,
    input  logic                            out_ready,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            locked,
    output logic [7:0]                      drop_count,
    output logic [31:0]                     err_signal,
    input  logic                            err_clear
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [3:0]  NOC_NORMAL       = 4'd1;
    localparam logic [3:0]  FT_HEAD          = 4'd0;
    localparam logic [3:0]  FT_TAIL          = 4'd2;
    localparam logic [31:0] TX_NOT_REACHABLE = 32'h2;

    typedef enum logic [0:0] {
        IDLE,
        LOCKED
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         grant_q, grant_d;
    logic [IW-1:0]         rr_q, rr_d;
    logic                  out_valid_q, out_valid_d;
    logic [FLIT_WIDTH-1:0] out_flit_q, out_flit_d;
    logic [7:0]            drop_q, drop_d;
    logic [31:0]           err_q, err_d;
    logic [CW-1:0]         stall_q, stall_d;

    logic [3:0]    ftype [NUM_REQ];
    logic          slot_free;
    logic          win_found;
    logic [IW-1:0] win_idx;
    logic          orph_found;
    logic [IW-1:0] orph_idx;
    logic          stall;
    logic          timeout_hit;

    // Per-requester flit type and the output slot availability
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            ftype[i] = req_flit[i*FLIT_WIDTH + FLIT_WIDTH - 8 +: 4];
        end
        slot_free = !out_valid_q | out_ready;
    end

    // Round-robin HEAD winner from the pointer, and lowest-index orphan
    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        orph_found = 1'b0;
        orph_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int j;
            j = int'(rr_q) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!win_found && req_valid[j] && ftype[j] == FT_HEAD) begin
                win_found = 1'b1;
                win_idx   = IW'(j);
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && ftype[i] != FT_HEAD) begin
                orph_found = 1'b1;
                orph_idx   = IW'(i);
            end
        end
    end

    // Arbitration FSM next state, handshake and output slot load
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        req_ready   = '0;
        out_valid_d = out_valid_q & !out_ready;
        out_flit_d  = out_flit_q;
        drop_d      = drop_q;
        unique case (state_q)
            IDLE: begin
                if (orph_found) begin
                    req_ready[orph_idx] = 1'b1;
                    if (drop_q != 8'hFF) begin
                        drop_d = drop_q + 8'd1;
                    end
                end
                if (win_found && slot_free && noc_state == NOC_NORMAL) begin
                    req_ready[win_idx] = 1'b1;
                    grant_d     = win_idx;
                    rr_d        = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                    state_d     = LOCKED;
                    out_valid_d = 1'b1;
                    out_flit_d  = req_flit[int'(win_idx)*FLIT_WIDTH +: FLIT_WIDTH];
                end
            end
            LOCKED: begin
                req_ready[grant_q] = slot_free;
                if (slot_free && req_valid[grant_q]) begin
                    out_valid_d = 1'b1;
                    out_flit_d  = req_flit[int'(grant_q)*FLIT_WIDTH +: FLIT_WIDTH];
                    if (ftype[grant_q] == FT_TAIL) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stall counter and sticky unreachable-transmitter error
    always_comb begin
        stall       = out_valid_q & !out_ready;
        timeout_hit = stall && (stall_q == CW'(TIMEOUT_CYCLES - 1));
        stall_d     = '0;
        if (stall) begin
            stall_d = timeout_hit ? stall_q : stall_q + 1'b1;
        end
        err_d = err_clear ? 32'h0 : err_q;
        if (timeout_hit) begin
            err_d = err_d | TX_NOT_REACHABLE;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_q        <= '0;
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
            drop_q      <= '0;
            err_q       <= '0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            out_valid_q <= out_valid_d;
            out_flit_q  <= out_flit_d;
            drop_q      <= drop_d;
            err_q       <= err_d;
            stall_q     <= stall_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_flit   = out_flit_q;
    assign grant_id   = grant_q;
    assign locked     = (state_q == LOCKED);
    assign drop_count = drop_q;
    assign err_signal = err_q;

endmodule

// File: tb/tb_flit_tx_arbiter.sv
// Scoreboard bench for flit_tx_arbiter: packet-level reference model,
// directed scenarios followed by randomized traffic.
module tb_flit_tx_arbiter;

    localparam int N  = 4;
    localparam int FW = 128;
    localparam int T  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      noc_state = 4'd1;
    logic [N-1:0]    req_valid = '0;
    logic [N*FW-1:0] req_flit = '0;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic [FW-1:0]   out_flit;
    logic            out_ready = 1'b0;
    logic [1:0]      grant_id;
    logic            locked;
    logic [7:0]      drop_count;
    logic [31:0]     err_signal;
    logic            err_clear = 1'b0;

    flit_tx_arbiter #(
        .NUM_REQ(N),
        .FLIT_WIDTH(FW),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .noc_state(noc_state),
        .req_valid(req_valid),
        .req_flit(req_flit),
        .req_ready(req_ready),
        .out_valid(out_valid),
        .out_flit(out_flit),
        .out_ready(out_ready),
        .grant_id(grant_id),
        .locked(locked),
        .drop_count(drop_count),
        .err_signal(err_signal),
        .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    int            n_chk  = 0;
    int            n_fail = 0;
    int            seq    = 0;
    logic [FW-1:0] src [N][$];
    logic [N-1:0]  gate = '1;
    logic [FW-1:0] exp_q [$];

    task automatic chk(input string nm, input logic [FW-1:0] act,
                       input logic [FW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] ty(input logic [FW-1:0] f);
        return f[123:120];
    endfunction

    function automatic logic [FW-1:0] mk(input int r, input logic [3:0] t);
        logic [FW-1:0] f;
        f[127:124] = 4'h1;
        f[123:120] = t;
        f[119:112] = {r[1:0], seq[5:0]};
        f[111:16]  = {$urandom, $urandom, $urandom};
        f[15:0]    = 16'($urandom);
        seq++;
        return f;
    endfunction

    task automatic pkt(input int r, input int nbody);
        src[r].push_back(mk(r, 4'd0));
        for (int b = 0; b < nbody; b++) begin
            src[r].push_back(mk(r, ($urandom_range(0, 4) == 0) ? 4'd9 : 4'd1));
        end
        src[r].push_back(mk(r, 4'd2));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int  cyc;
        bit  busy;
        cyc  = 0;
        busy = 1'b1;
        while (busy && cyc < 400) begin
            step();
            cyc++;
            busy = out_valid || exp_q.size() != 0;
            for (int i = 0; i < N; i++) begin
                if (src[i].size() != 0) busy = 1'b1;
            end
        end
        if (busy) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: traffic still pending after %0d cycles", cyc);
        end
    endtask

    // Source driver: pops a flit once the DUT accepted it
    initial begin
        logic [N-1:0] acc;
        forever begin
            @(negedge clk);
            #2;
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i] && src[i].size() != 0) void'(src[i].pop_front());
                req_valid[i] = gate[i] && src[i].size() != 0;
                req_flit[i*FW +: FW] = (src[i].size() != 0) ? src[i][0] : '0;
            end
        end
    end

    // Reference model: checks control outputs and predicts forwarded flits
    initial begin
        int           owner, ptr, lastg, drops, nst, j;
        bit           mov, err, sf, nmov, nerr;
        logic [N-1:0] er;
        owner = -1; ptr = 0; lastg = 0; drops = 0; nst = 0;
        mov = 0; err = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            #1;
            chk("locked", FW'(locked), FW'(owner >= 0));
            chk("grant_id", FW'(grant_id), FW'(lastg));
            chk("drop_count", FW'(drop_count), FW'(drops));
            chk("err_signal", FW'(err_signal), err ? FW'(2) : FW'(0));
            chk("out_valid", FW'(out_valid), FW'(mov));
            sf = !mov || out_ready;
            er = '0;
            if (owner < 0) begin
                for (int i = 0; i < N; i++) begin
                    if (req_valid[i] && ty(req_flit[i*FW +: FW]) != 0 && er == '0)
                        er[i] = 1'b1;
                end
                if (sf && noc_state == 4'd1) begin
                    for (int k = 0; k < N; k++) begin
                        j = (ptr + k) % N;
                        if (req_valid[j] && ty(req_flit[j*FW +: FW]) == 0) begin
                            er[j] = 1'b1;
                            break;
                        end
                    end
                end
            end else begin
                er[owner] = sf;
            end
            chk("req_ready", FW'(req_ready), FW'(er));
            nmov = mov && !out_ready;
            if (owner < 0) begin
                for (int i = 0; i < N; i++) begin
                    if (er[i] && req_valid[i]) begin
                        if (ty(req_flit[i*FW +: FW]) != 0) begin
                            if (drops < 255) drops++;
                        end else begin
                            exp_q.push_back(req_flit[i*FW +: FW]);
                            owner = i;
                            lastg = i;
                            ptr   = (i + 1) % N;
                            nmov  = 1'b1;
                        end
                    end
                end
            end else if (er[owner] && req_valid[owner]) begin
                exp_q.push_back(req_flit[owner*FW +: FW]);
                nmov = 1'b1;
                if (ty(req_flit[owner*FW +: FW]) == 4'd2) owner = -1;
            end
            if (mov && !out_ready) nst++;
            else nst = 0;
            nerr = err_clear ? 1'b0 : err;
            if (nst >= T) nerr = 1'b1;
            if (rst) begin
                owner = -1; ptr = 0; lastg = 0; drops = 0; nst = 0;
                mov = 0; err = 0;
                exp_q.delete();
            end else begin
                mov = nmov;
                err = nerr;
            end
        end
    end

    // Monitor: compares every presented flit with the scoreboard head
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL out_unexpected: got %0h expected none", out_flit);
                end else begin
                    chk("out_flit", out_flit, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        step();
        @(negedge clk);
        chk("rst_out_valid", FW'(out_valid), '0);
        chk("rst_out_flit", out_flit, '0);
        chk("rst_req_ready", FW'(req_ready), '0);
        chk("rst_locked", FW'(locked), '0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;

        // Single packet from requester 0
        pkt(0, 1);
        drain();

        // Fairness: every requester queues two HEAD/TAIL packets
        for (int r = 0; r < N; r++) begin
            pkt(r, 0);
            pkt(r, 0);
        end
        drain();

        // Lock hold: req2 HEAD arrives while req1 is mid-packet
        pkt(1, 2);
        step();
        pkt(2, 0);
        drain();

        // Backpressure long enough to raise the timeout, then clear it
        pkt(0, 3);
        step();
        step();
        out_ready = 1'b0;
        repeat (5) step();
        out_ready = 1'b1;
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        drain();

        // Orphan drop, then HEAD held off while the NoC initializes
        src[3].push_back(mk(3, 4'd1));
        repeat (3) step();
        noc_state = 4'd0;
        pkt(1, 0);
        repeat (4) step();
        noc_state = 4'd1;
        drain();

        // Reset mid-packet, then a fresh packet from another requester
        pkt(0, 2);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        pkt(2, 1);
        drain();

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            gate      = N'($urandom);
            gate      = gate | N'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            noc_state = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 2)) : 4'd1;
            err_clear = ($urandom_range(0, 31) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 2) == 0) begin
                int r;
                r = $urandom_range(0, N - 1);
                if (src[r].size() < 8) begin
                    if ($urandom_range(0, 9) == 0)
                        src[r].push_back(mk(r, ($urandom_range(0, 1) == 0) ? 4'd1 : 4'd7));
                    else
                        pkt(r, $urandom_range(0, 3));
                end
            end
            step();
        end
        gate      = '1;
        out_ready = 1'b1;
        noc_state = 4'd1;
        err_clear = 1'b0;
        rst       = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/flit_tx_arbiter.md
Name: flit_tx_arbiter

Overview:
- Packet-level round-robin arbiter sharing one router transmit link between NUM_REQ flit sources, e.g. local injection and per-port forwarding buffers.
- Grant is locked from a HEAD flit through its matching TAIL flit, so flits from different packets never interleave on the link.
- The output is a registered single-entry stage with a valid/ready handshake.
- The block gates new grants on the NoC state and flags an unreachable transmitter with a stall timeout.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- FLIT_WIDTH, 128, flit width; flit layout is version[127:124], flittype[123:120], flit_id[119:112], payload, checksum[15:0].
- TIMEOUT_CYCLES, 1024, number of consecutive stalled cycles before TX_NOT_REACHABLE is raised.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- noc_state  in  4  noc_state_t; INITIALIZING=0, NORMAL=1, ERROR=2
- req_valid  in  NUM_REQ  per-requester flit valid
- req_flit  in  NUM_REQ*FLIT_WIDTH  flits; requester i occupies bits [i*FLIT_WIDTH +: FLIT_WIDTH]
- req_ready  out  NUM_REQ  per-requester accept
- out_valid  out  1  output flit valid
- out_flit  out  FLIT_WIDTH  output flit
- out_ready  in  1  link accepts the output flit
- grant_id  out  $clog2(NUM_REQ)  owner of the current or last packet
- locked  out  1  a packet is in progress
- drop_count  out  8  saturating count of discarded orphan flits
- err_signal  out  32  signal_t; NO_ERROR=0, TX_NOT_REACHABLE=2
- err_clear  in  1  clears err_signal

Behaviour:
- Reset values: out_valid=0, out_flit=0, req_ready=0, grant_id=0, locked=0, drop_count=0, err_signal=0, RR pointer=0, stall counter=0, state=IDLE. A reset mid-packet abandons the packet with no TAIL emitted.
- Output slot: slot_free = !out_valid | out_ready.
- Transfer rule: a flit moves from requester i when req_valid[i] & req_ready[i]. It appears on out_flit the next cycle (latency 1). out_valid clears when the slot is consumed and nothing new is loaded.
- req_ready is combinational from state, RR pointer, noc_state, slot_free and req_valid. At most one bit is ever set, except for orphan drops (see below).
- State IDLE, arbitration:
  - Eligible requesters: req_valid[i] and flittype==HEAD(0) and noc_state==NORMAL.
  - Winner: first eligible at or after the RR pointer, searching upward with wrap.
  - If slot_free: req_ready[winner]=1, grant_id<=winner, RR pointer<=winner+1 mod NUM_REQ, goto LOCKED, locked=1.
  - If a HEAD transfers and no other flit of the packet follows, stay LOCKED until TAIL.
- State LOCKED:
  - Only grant_id is served: req_ready[grant_id] = slot_free.
  - BODY(1) and HEAD flits forward and keep the lock.
  - A TAIL(2) transfer returns to IDLE at the next edge. The next arbitration can transfer in the cycle after the TAIL, so there are no dead cycles beyond that.
  - Other requesters see req_ready=0.
- Orphan flits:
  - In IDLE, a valid flit with flittype != HEAD is accepted (req_ready=1) and discarded, never forwarded. drop_count increments and saturates at 255.
  - Only the lowest-index orphan is dropped per cycle. Orphan dropping is independent of slot_free and of noc_state.
- Unknown flittype values (3..15) are treated as BODY while LOCKED and as orphans while IDLE.
- noc_state != NORMAL: no new grants are issued. An in-progress LOCKED packet completes through its TAIL.
- Stall timeout:
  - The stall counter increments while out_valid & !out_ready and resets to 0 on any cycle where that is false.
  - When it reaches TIMEOUT_CYCLES-1 and the stall persists, err_signal |= TX_NOT_REACHABLE.
  - The error is sticky until err_clear or rst. Data flow is unaffected.
  - If err_clear and a new timeout occur in the same cycle, set wins.
- Simultaneous events: output consumption and a new load in the same cycle keep out_valid=1 with the new flit. A TAIL load and new HEAD requests in the same cycle: new HEADs wait one cycle.

Test Plan:
- Single packet: req0 sends HEAD, BODY, TAIL with out_ready=1 -> out_flit carries the same 3 flits on cycles t+1..t+3; locked is high after HEAD and low after TAIL; grant_id=0.
- Fairness: all 4 requesters hold 2-flit packets (HEAD, TAIL) continuously, pointer at 0 -> packet grant order is 0,1,2,3,0, and no flits interleave.
- Lock hold: req1 is mid-packet while req2 presents HEAD -> req_ready[2]=0 until the cycle after req1's TAIL transfers; req2 is then granted.
- Backpressure: out_ready=0 for 5 cycles mid-packet -> out_flit holds stable, req_ready=0, no loss; with TIMEOUT_CYCLES=4 -> err_signal=0x2 on the 4th stalled cycle, cleared by err_clear.
- Orphan plus state gating: req3 presents BODY while IDLE -> dropped, drop_count=1. With noc_state=INITIALIZING and HEAD pending -> no grant; after switching to NORMAL -> grant the next cycle.
- Reset mid-packet: assert rst after HEAD and BODY -> all outputs return to reset values the next cycle; a subsequent HEAD from another requester is granted normally.
